mc_ctrl: RTL and testbench
==========================

# mc_ctrl

Parametrised multi-cycle control sequencer for the MIPS core. It replaces the fixed five-phase controller with a handshake-driven FSM, and adds:
- variable-latency instruction and data memory via req/ack,
- a per-opcode phase skip,
- illegal-opcode trapping,
- a retired-instruction counter.

It drives the t1..t5 phase strobes and the datapath mux/enable selects consumed by the PC, register file, ALU, branch and data-memory blocks.

## Interface
- OP_W, 6, opcode field width
- INSTR_W, 32, retired-instruction counter width
- TMO_W, 8, timeout counter width
- TMO_CYC, 200, cycles waited for an ack before trapping (must be < 2^TMO_W)

- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- op  in  OP_W  opcode from instruction decode, valid from the cycle after t1
- stall  in  1  hold the FSM in ID/EX/WB; no strobe while high
- imem_req  out  1  instruction fetch request
- imem_ack  in  1  fetch complete; IR is valid this cycle
- dmem_req  out  1  data memory access request
- dmem_ack  in  1  data access complete
- t1,t2,t3,t4,t5  out  1 each  phase-complete strobes (IF, ID, EX, MEM, WB)
- s31,s32,s51,sf,dwe,jwe,ju  out  1 each  datapath selects (1 selects the mux y input)
- rwe  out  1  register write enable
- instret  out  INSTR_W  retired-instruction count
- err  out  1  sticky trap flag
- err_code  out  2  01 illegal opcode, 10 memory timeout

## Operation
States: IF, ID, EX, MEM, WB, ERR.

- **IF:** imem_req=1. On imem_ack: pulse t1, go to ID.
- **ID:** one cycle unless stall.
  - Pulse t2 and latch the decode registers from op.
  - Unknown op: go to ERR with err_code=01.
  - Otherwise go to EX.
- **EX:** pulse t3, then branch on op:
  - lw/sw: go to MEM.
  - R-type/addi: go to WB.
  - beq/j: go to IF, increment instret.
- **MEM:** dmem_req=1 and dwe held per decode. On dmem_ack: pulse t4.
  - lw: go to WB.
  - sw: go to IF, increment instret.
- **WB:** rwe=1 and t5 pulse for one cycle, go to IF, increment instret.
- **ERR:** all strobes, requests and rwe are 0. Sticky until rst.

Decode registers (latched at t2; held stable through retirement):
- R-type (0x00): s31=1, s32=0, sf=1, s51=1.
- addi (0x08): s31=1, s32=1, s51=1.
- lw (0x23): s31=1, s32=1, s51=0.
- sw (0x2B): s31=1, s32=1, dwe=1.
- beq (0x04): s31=0, s32=1, jwe=1.
- j (0x02): ju=1.
- Any field not listed is 0.

Other rules:
- rwe is gated: asserted only in the WB state, never from decode alone.
- stall is ignored in IF, MEM and ERR; ack handshakes govern those states.
- instret wraps modulo 2^INSTR_W.

## Timing
- Minimum instruction latency with zero-wait acks: beq/j 3 cycles, R-type/addi/sw 4 cycles, lw 5 cycles.
- Each wait cycle or stall cycle adds exactly one cycle.
- imem_req and dmem_req are combinational from state.
- An ack is honoured only in a cycle where its req is high. An ack arriving in the same cycle as req completes the phase that cycle.
- Strobes t1..t5 are registered-state decodes, high for exactly one cycle per phase.
- instret updates on the clock edge that leaves the retiring state.
- Reset: the cycle after rst, the state is IF. All of the following are 0: strobes, selects, rwe, dwe, instret, err, err_code. imem_req rises in the first cycle after rst deasserts.
- rst asserted mid-instruction (including MEM with an ack pending) aborts the instruction with no strobe and no instret increment.
- rst overrides every other input.

## Configuration
- MC_CTRL_TIMEOUT_EN defined:
  - A TMO_W counter clears on entry to IF/MEM and counts each cycle the ack is absent.
  - When the count reaches TMO_CYC without an ack, go to ERR with err_code=10.
  - An ack on the TMO_CYC-th cycle wins.
- Undefined: the counter is absent; IF/MEM wait indefinitely, and err_code=10 never occurs.

## Test plan
- rst for 3 cycles, then release, with op=0x00 and acks tied 1 → imem_req=1 in cycle 1; strobes t1,t2,t3,t5 on consecutive cycles; rwe=1 only with t5; instret=1 after 4 cycles.
- lw (0x23) with dmem_ack delayed 3 cycles → t4 on the 4th MEM cycle; s51=0; t5 next cycle; total 8 cycles; instret +1.
- Sequence beq, j, sw with zero-wait acks → latencies 3, 3, 4; dwe=1 throughout sw MEM; rwe never asserted; instret=3.
- op=0x3F → err=1, err_code=01 in the cycle after t2; no t3; FSM stays in ERR until rst.
- stall held 2 cycles in EX on addi → t3 delayed by 2; decode outputs stable; latency 6.
- With MC_CTRL_TIMEOUT_EN and TMO_CYC=4, imem_ack held 0 → err_code=10 after 4 IF cycles. Without the macro, imem_req stays 1 for 1000 cycles with err=0.

Source files
------------

// File: rtl/mc_ctrl_if.sv
// Handshake and datapath-control bundle between the multi-cycle sequencer and the MIPS core.
// master: sequencer side (drives strobes, selects, requests); slave: core/memory side.
// Carries opcode, stall, imem/dmem req/ack, t1..t5, selects, rwe, instret, err/err_code.
interface mc_ctrl_if #(
  parameter int OP_W    = 6,
  parameter int INSTR_W = 32
);
  logic [OP_W-1:0]    op;
  logic               stall;
  logic               imem_req;
  logic               imem_ack;
  logic               dmem_req;
  logic               dmem_ack;
  logic               t1, t2, t3, t4, t5;
  logic               s31, s32, s51, sf, dwe, jwe, ju;
  logic               rwe;
  logic [INSTR_W-1:0] instret;
  logic               err;
  logic [1:0]         err_code;

  modport master (
    input  op, stall, imem_ack, dmem_ack,
    output imem_req, dmem_req, t1, t2, t3, t4, t5,
           s31, s32, s51, sf, dwe, jwe, ju, rwe, instret, err, err_code
  );

  modport slave (
    output op, stall, imem_ack, dmem_ack,
    input  imem_req, dmem_req, t1, t2, t3, t4, t5,
           s31, s32, s51, sf, dwe, jwe, ju, rwe, instret, err, err_code
  );
endinterface

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control sequencer: IF/ID/EX/MEM/WB/ERR FSM with req/ack memory phases.
// Latency: beq/j 3, R-type/addi/sw 4, lw 5 cycles at zero wait; each wait/stall cycle adds one.
// Backpressure: imem/dmem ack stretches IF/MEM; stall holds ID/EX/WB with no strobe.
// Ports: clk, rst (sync, active-high), bus (mc_ctrl_if.master: op, stall, acks in;
//   reqs, t1..t5, selects, rwe, instret, err, err_code out).
// Optional MC_CTRL_TIMEOUT_EN: traps to ERR (err_code 10) after TMO_CYC ack-less cycles.
module mc_ctrl #(
  parameter int OP_W    = 6,
  parameter int INSTR_W = 32,
  parameter int TMO_W   = 8,
  parameter int TMO_CYC = 200
) (
  input  logic       clk,
  input  logic       rst,
  mc_ctrl_if.master  bus
);

  typedef enum logic [2:0] {S_IF, S_ID, S_EX, S_MEM, S_WB, S_ERR} state_t;
  // What EX does next, decided at decode time.
  typedef enum logic [1:0] {K_WB, K_MEM, K_RET} kind_t;

  localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'h00);
  localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(6'h08);
  localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'h23);
  localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'h2B);
  localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'h04);
  localparam logic [OP_W-1:0] OP_J     = OP_W'(6'h02);

  state_t             r_state;
  kind_t              r_kind;
  logic               r_is_lw;
  logic               r_s31, r_s32, r_s51, r_sf, r_dwe, r_jwe, r_ju;
  logic [INSTR_W-1:0] r_instret;
  logic               r_err;
  logic [1:0]         r_err_code;
  logic               w_tmo_hit;

`ifdef MC_CTRL_TIMEOUT_EN
  logic [TMO_W-1:0]   r_tmo;

  // Counts consecutive ack-less cycles in IF/MEM; any ack or other state clears it,
  // so it is always zero on entry to IF or MEM.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tmo <= '0;
    end else if ((r_state == S_IF && !bus.imem_ack) || (r_state == S_MEM && !bus.dmem_ack)) begin
      r_tmo <= r_tmo + TMO_W'(1);
    end else begin
      r_tmo <= '0;
    end
  end

  // Hit on the TMO_CYC-th waiting cycle; an ack in that same cycle is checked first.
  assign w_tmo_hit = (r_tmo == TMO_W'(TMO_CYC - 1));
`else
  assign w_tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IF;
      r_kind     <= K_WB;
      r_is_lw    <= 1'b0;
      r_s31      <= 1'b0;
      r_s32      <= 1'b0;
      r_s51      <= 1'b0;
      r_sf       <= 1'b0;
      r_dwe      <= 1'b0;
      r_jwe      <= 1'b0;
      r_ju       <= 1'b0;
      r_instret  <= '0;
      r_err      <= 1'b0;
      r_err_code <= 2'b00;
    end else begin
      case (r_state)
        S_IF: begin
          if (bus.imem_ack) begin
            r_state <= S_ID;
          end else if (w_tmo_hit) begin
            r_state    <= S_ERR;
            r_err      <= 1'b1;
            r_err_code <= 2'b10;
          end
        end
        S_ID: begin
          if (!bus.stall) begin
            // Clear all decode fields, then set the ones this opcode uses.
            r_state <= S_EX;
            r_kind  <= K_WB;
            r_is_lw <= 1'b0;
            r_s31   <= 1'b0;
            r_s32   <= 1'b0;
            r_s51   <= 1'b0;
            r_sf    <= 1'b0;
            r_dwe   <= 1'b0;
            r_jwe   <= 1'b0;
            r_ju    <= 1'b0;
            case (bus.op)
              OP_RTYPE: begin r_s31 <= 1'b1; r_sf <= 1'b1; r_s51 <= 1'b1; end
              OP_ADDI:  begin r_s31 <= 1'b1; r_s32 <= 1'b1; r_s51 <= 1'b1; end
              OP_LW:    begin r_s31 <= 1'b1; r_s32 <= 1'b1; r_kind <= K_MEM; r_is_lw <= 1'b1; end
              OP_SW:    begin r_s31 <= 1'b1; r_s32 <= 1'b1; r_dwe <= 1'b1; r_kind <= K_MEM; end
              OP_BEQ:   begin r_s32 <= 1'b1; r_jwe <= 1'b1; r_kind <= K_RET; end
              OP_J:     begin r_ju <= 1'b1; r_kind <= K_RET; end
              default: begin
                r_state    <= S_ERR;
                r_err      <= 1'b1;
                r_err_code <= 2'b01;
              end
            endcase
          end
        end
        S_EX: begin
          if (!bus.stall) begin
            case (r_kind)
              K_MEM:   r_state <= S_MEM;
              K_RET: begin
                r_state   <= S_IF;
                r_instret <= r_instret + INSTR_W'(1);
              end
              default: r_state <= S_WB;
            endcase
          end
        end
        S_MEM: begin
          if (bus.dmem_ack) begin
            if (r_is_lw) begin
              r_state <= S_WB;
            end else begin
              r_state   <= S_IF;
              r_instret <= r_instret + INSTR_W'(1);
            end
          end else if (w_tmo_hit) begin
            r_state    <= S_ERR;
            r_err      <= 1'b1;
            r_err_code <= 2'b10;
          end
        end
        S_WB: begin
          if (!bus.stall) begin
            r_state   <= S_IF;
            r_instret <= r_instret + INSTR_W'(1);
          end
        end
        default: r_state <= S_ERR;
      endcase
    end
  end

  // Requests and strobes are state decodes qualified by ack/stall; rst masks them so an
  // aborted phase never strobes and imem_req only rises once rst is low.
  assign bus.imem_req = !rst && (r_state == S_IF);
  assign bus.dmem_req = !rst && (r_state == S_MEM);
  assign bus.t1       = bus.imem_req && bus.imem_ack;
  assign bus.t2       = !rst && (r_state == S_ID) && !bus.stall;
  assign bus.t3       = !rst && (r_state == S_EX) && !bus.stall;
  assign bus.t4       = bus.dmem_req && bus.dmem_ack;
  assign bus.t5       = !rst && (r_state == S_WB) && !bus.stall;
  assign bus.rwe      = bus.t5;

  assign bus.s31      = r_s31;
  assign bus.s32      = r_s32;
  assign bus.s51      = r_s51;
  assign bus.sf       = r_sf;
  assign bus.dwe      = r_dwe;
  assign bus.jwe      = r_jwe;
  assign bus.ju       = r_ju;
  assign bus.instret  = r_instret;
  assign bus.err      = r_err;
  assign bus.err_code = r_err_code;

endmodule

// File: tb/tb_mc_ctrl.sv
// Testbench for mc_ctrl: per-cycle vector table for the main instruction flow,
// plus hand sequences for reset abort, illegal-opcode trap and ack timeout/wait.
// Inputs change 1 time unit after posedge; outputs are checked at negedge.
module tb_mc_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mc_ctrl_if #(.OP_W(6), .INSTR_W(32)) bus ();

  mc_ctrl #(.OP_W(6), .INSTR_W(32), .TMO_W(8), .TMO_CYC(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic        stall, ia, da;
    logic        ireq, dreq;
    logic [4:0]  strb;
    logic        rwe;
    logic [6:0]  sel;
    logic        err;
    logic [1:0]  code;
    logic [31:0] ir;
  } vec_t;

  localparam logic [5:0] OR_ = 6'h00, OA = 6'h08, OL = 6'h23, OS = 6'h2B, OB = 6'h04, OJ = 6'h02;
  // selects packed as {s31,s32,s51,sf,dwe,jwe,ju}
  localparam logic [6:0] SZ = 7'b0000000, SR = 7'b1011000, SA = 7'b1110000, SL = 7'b1100000,
                         SS = 7'b1100100, SB = 7'b0100010, SJ = 7'b0000001;
  // strobes packed as {t5,t4,t3,t2,t1}
  localparam logic [4:0] N = 5'b00000, T1 = 5'b00001, T2 = 5'b00010, T3 = 5'b00100,
                         T4 = 5'b01000, T5 = 5'b10000;

  int n_checks = 0;
  int n_fail   = 0;
  vec_t tbl[42];

  function automatic vec_t mk(input logic r, input logic [5:0] op, input logic st, input logic ia,
                              input logic da, input logic ireq, input logic dreq,
                              input logic [4:0] strb, input logic rwe, input logic [6:0] sel,
                              input logic err, input logic [1:0] code, input logic [31:0] ir);
    vec_t v;
    v.rst = r; v.op = op; v.stall = st; v.ia = ia; v.da = da;
    v.ireq = ireq; v.dreq = dreq; v.strb = strb; v.rwe = rwe; v.sel = sel;
    v.err = err; v.code = code; v.ir = ir;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [5:0] op, input logic st, input logic ia,
                       input logic da);
    rst = r; bus.op = op; bus.stall = st; bus.imem_ack = ia; bus.dmem_ack = da;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] strobes();
    return {bus.t5, bus.t4, bus.t3, bus.t2, bus.t1};
  endfunction

  function automatic logic [6:0] sels();
    return {bus.s31, bus.s32, bus.s51, bus.sf, bus.dwe, bus.jwe, bus.ju};
  endfunction

  initial begin
    // Reset, R-type, lw with 3 dmem wait cycles, beq, j, sw, sw with a wait,
    // IF wait, addi with 2 EX stalls, R-type with ID and WB stalls.
    tbl[0]  = mk(1, OR_, 0, 1, 1, 0, 0, N,  0, SZ, 0, 0, 0);
    tbl[1]  = mk(0, OR_, 0, 1, 1, 1, 0, T1, 0, SZ, 0, 0, 0);
    tbl[2]  = mk(0, OR_, 0, 1, 1, 0, 0, T2, 0, SZ, 0, 0, 0);
    tbl[3]  = mk(0, OR_, 0, 1, 1, 0, 0, T3, 0, SR, 0, 0, 0);
    tbl[4]  = mk(0, OR_, 0, 1, 1, 0, 0, T5, 1, SR, 0, 0, 0);
    tbl[5]  = mk(0, OL,  0, 1, 0, 1, 0, T1, 0, SR, 0, 0, 1);
    tbl[6]  = mk(0, OL,  0, 1, 0, 0, 0, T2, 0, SR, 0, 0, 1);
    tbl[7]  = mk(0, OL,  0, 1, 0, 0, 0, T3, 0, SL, 0, 0, 1);
    tbl[8]  = mk(0, OL,  0, 1, 0, 0, 1, N,  0, SL, 0, 0, 1);
    tbl[9]  = mk(0, OL,  0, 1, 0, 0, 1, N,  0, SL, 0, 0, 1);
    tbl[10] = mk(0, OL,  0, 1, 0, 0, 1, N,  0, SL, 0, 0, 1);
    tbl[11] = mk(0, OL,  0, 1, 1, 0, 1, T4, 0, SL, 0, 0, 1);
    tbl[12] = mk(0, OL,  0, 1, 1, 0, 0, T5, 1, SL, 0, 0, 1);
    tbl[13] = mk(0, OB,  0, 1, 1, 1, 0, T1, 0, SL, 0, 0, 2);
    tbl[14] = mk(0, OB,  0, 1, 1, 0, 0, T2, 0, SL, 0, 0, 2);
    tbl[15] = mk(0, OB,  0, 1, 1, 0, 0, T3, 0, SB, 0, 0, 2);
    tbl[16] = mk(0, OJ,  0, 1, 1, 1, 0, T1, 0, SB, 0, 0, 3);
    tbl[17] = mk(0, OJ,  0, 1, 1, 0, 0, T2, 0, SB, 0, 0, 3);
    tbl[18] = mk(0, OJ,  0, 1, 1, 0, 0, T3, 0, SJ, 0, 0, 3);
    tbl[19] = mk(0, OS,  0, 1, 1, 1, 0, T1, 0, SJ, 0, 0, 4);
    tbl[20] = mk(0, OS,  0, 1, 1, 0, 0, T2, 0, SJ, 0, 0, 4);
    tbl[21] = mk(0, OS,  0, 1, 1, 0, 0, T3, 0, SS, 0, 0, 4);
    tbl[22] = mk(0, OS,  0, 1, 1, 0, 1, T4, 0, SS, 0, 0, 4);
    tbl[23] = mk(0, OS,  0, 1, 0, 1, 0, T1, 0, SS, 0, 0, 5);
    tbl[24] = mk(0, OS,  0, 1, 0, 0, 0, T2, 0, SS, 0, 0, 5);
    tbl[25] = mk(0, OS,  0, 1, 0, 0, 0, T3, 0, SS, 0, 0, 5);
    tbl[26] = mk(0, OS,  0, 1, 0, 0, 1, N,  0, SS, 0, 0, 5);
    tbl[27] = mk(0, OS,  0, 1, 1, 0, 1, T4, 0, SS, 0, 0, 5);
    tbl[28] = mk(0, OA,  0, 0, 1, 1, 0, N,  0, SS, 0, 0, 6);
    tbl[29] = mk(0, OA,  0, 1, 1, 1, 0, T1, 0, SS, 0, 0, 6);
    tbl[30] = mk(0, OA,  0, 1, 1, 0, 0, T2, 0, SS, 0, 0, 6);
    tbl[31] = mk(0, OA,  1, 1, 1, 0, 0, N,  0, SA, 0, 0, 6);
    tbl[32] = mk(0, OA,  1, 1, 1, 0, 0, N,  0, SA, 0, 0, 6);
    tbl[33] = mk(0, OA,  0, 1, 1, 0, 0, T3, 0, SA, 0, 0, 6);
    tbl[34] = mk(0, OA,  0, 1, 1, 0, 0, T5, 1, SA, 0, 0, 6);
    tbl[35] = mk(0, OR_, 1, 1, 1, 1, 0, T1, 0, SA, 0, 0, 7);
    tbl[36] = mk(0, OR_, 1, 1, 1, 0, 0, N,  0, SA, 0, 0, 7);
    tbl[37] = mk(0, OR_, 0, 1, 1, 0, 0, T2, 0, SA, 0, 0, 7);
    tbl[38] = mk(0, OR_, 0, 1, 1, 0, 0, T3, 0, SR, 0, 0, 7);
    tbl[39] = mk(0, OR_, 1, 1, 1, 0, 0, N,  0, SR, 0, 0, 7);
    tbl[40] = mk(0, OR_, 0, 1, 1, 0, 0, T5, 1, SR, 0, 0, 7);
    tbl[41] = mk(0, OR_, 0, 0, 1, 1, 0, N,  0, SR, 0, 0, 8);

    drive(1, OR_, 0, 1, 1);
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 42; i++) begin
      drive(tbl[i].rst, tbl[i].op, tbl[i].stall, tbl[i].ia, tbl[i].da);
      @(negedge clk);
      chk($sformatf("vec[%0d]", i),
          64'({bus.imem_req, bus.dmem_req, strobes(), bus.rwe, sels(), bus.err, bus.err_code, bus.instret}),
          64'({tbl[i].ireq, tbl[i].dreq, tbl[i].strb, tbl[i].rwe, tbl[i].sel, tbl[i].err, tbl[i].code, tbl[i].ir}));
      tick();
    end

    // Reset while in MEM with dmem_ack high: no t4, no retire, counter and selects cleared.
    drive(0, OL, 0, 1, 0); tick();   // IF
    tick();                          // ID
    tick();                          // EX
    drive(1, OL, 0, 1, 1);           // MEM + rst
    @(negedge clk);
    chk("rst_mem_strobes", 64'({strobes(), bus.dmem_req, bus.rwe}), 64'd0);
    tick();
    drive(0, OL, 0, 0, 0);
    @(negedge clk);
    chk("rst_mem_after", 64'({bus.imem_req, sels(), bus.instret}), 64'({1'b1, SZ, 32'd0}));
    tick();

    // Illegal opcode: t2 pulses, then sticky ERR with err_code 01 and no t3.
    drive(0, 6'h3F, 0, 1, 1); tick(); // IF
    @(negedge clk);
    chk("illegal_t2", 64'(strobes()), 64'(T2));
    tick();
    @(negedge clk);
    chk("illegal_err", 64'({bus.err, bus.err_code, bus.t3, bus.imem_req}), 64'({1'b1, 2'b01, 1'b0, 1'b0}));
    tick();
    for (int i = 0; i < 8; i++) begin
      drive(0, OR_, 1'(i % 2), 1, 1);
      @(negedge clk);
      chk($sformatf("err_sticky[%0d]", i),
          64'({strobes(), bus.imem_req, bus.dmem_req, bus.rwe, bus.err, bus.err_code}),
          64'({N, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01}));
      tick();
    end
    drive(1, OR_, 0, 0, 0); tick();
    drive(0, OR_, 0, 0, 0);
    @(negedge clk);
    chk("err_cleared", 64'({bus.err, bus.err_code, bus.imem_req}), 64'({1'b0, 2'b00, 1'b1}));
    drive(1, OR_, 0, 0, 0); tick();

`ifdef MC_CTRL_TIMEOUT_EN
    // Ack on the 4th waiting cycle still wins.
    for (int i = 0; i < 3; i++) begin
      drive(0, OR_, 0, 0, 0); tick();
    end
    drive(0, OR_, 0, 1, 0);
    @(negedge clk);
    chk("tmo_ack_wins_t1", 64'(bus.t1), 64'd1);
    tick();
    @(negedge clk);
    chk("tmo_ack_wins_noerr", 64'({bus.err, bus.t2}), 64'({1'b0, 1'b1}));
    tick(); // EX
    tick(); // WB
    for (int i = 0; i < 4; i++) begin
      drive(0, OR_, 0, 0, 0);
      @(negedge clk);
      chk($sformatf("tmo_wait[%0d]", i), 64'({bus.imem_req, bus.err}), 64'({1'b1, 1'b0}));
      tick();
    end
    @(negedge clk);
    chk("tmo_trap", 64'({bus.err, bus.err_code, bus.imem_req}), 64'({1'b1, 2'b10, 1'b0}));
    tick();
`else
    // Without the timeout, IF waits indefinitely for imem_ack.
    begin
      int bad;
      bad = 0;
      drive(0, OR_, 0, 0, 0);
      for (int i = 0; i < 1000; i++) begin
        @(negedge clk);
        if (bus.imem_req !== 1'b1 || bus.err !== 1'b0) bad++;
        tick();
      end
      chk("no_tmo_1000cyc_bad", 64'(bad), 64'd0);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
